// File: rtl/alu_mem_unit_if.sv
// Bus between the register file/control unit and the execute+memory slice.
// Everything except the clock and reset travels on this interface.
interface alu_mem_unit_if;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_read_data;

    // Control/datapath side: drives operands and controls, observes results.
    modport master (
        output alu_op, funct, shamt, rs_data, rt_data, imm_ext,
               alu_src, mem_read, mem_write,
        input  alu_ctrl, alu_result, zero, mem_read_data
    );

    // Execute+memory slice.
    modport slave (
        input  alu_op, funct, shamt, rs_data, rt_data, imm_ext,
               alu_src, mem_read, mem_write,
        output alu_ctrl, alu_result, zero, mem_read_data
    );
endinterface

// File: rtl/alu_mem_unit.sv
// Execute + data-memory slice of a single-cycle MIPS datapath.
// ALU decode and datapath are combinational; only the data memory holds
// state. The ALU result doubles as the byte address for loads/stores.
module alu_mem_unit #(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_mem_unit_if.slave  bus
);

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_SLL = 4'b1000;
    localparam logic [3:0] C_SRL = 4'b1001;
    localparam logic [3:0] C_SRA = 4'b1010;
    localparam logic [3:0] C_LUI = 4'b1011;
    localparam logic [3:0] C_NOR = 4'b1100;

    logic [3:0]           w_alu_ctrl;
    logic [31:0]          w_b;
    logic [31:0]          w_result;
    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]          r_mem [MEM_WORDS];

    // Map main-control opcode (and funct for R-type) onto an ALU operation.
    always_comb begin
        w_alu_ctrl = C_ADD;
        case (bus.alu_op)
            3'b000: w_alu_ctrl = C_ADD;
            3'b001: w_alu_ctrl = C_SUB;
            3'b010: begin
                case (bus.funct)
                    6'b100000, 6'b100001: w_alu_ctrl = C_ADD;
                    6'b100010, 6'b100011: w_alu_ctrl = C_SUB;
                    6'b100100:            w_alu_ctrl = C_AND;
                    6'b100101:            w_alu_ctrl = C_OR;
                    6'b100110:            w_alu_ctrl = C_XOR;
                    6'b100111:            w_alu_ctrl = C_NOR;
                    6'b101010:            w_alu_ctrl = C_SLT;
                    6'b000000:            w_alu_ctrl = C_SLL;
                    6'b000010:            w_alu_ctrl = C_SRL;
                    6'b000011:            w_alu_ctrl = C_SRA;
                    default:              w_alu_ctrl = C_ADD;
                endcase
            end
            3'b011: w_alu_ctrl = C_AND;
            3'b100: w_alu_ctrl = C_OR;
            3'b101: w_alu_ctrl = C_SLT;
            3'b110: w_alu_ctrl = C_XOR;
            3'b111: w_alu_ctrl = C_LUI;
            default: w_alu_ctrl = C_ADD;
        endcase
    end

    assign w_b = bus.alu_src ? bus.imm_ext : bus.rt_data;

    // 32-bit ALU; unassigned control codes yield zero.
    always_comb begin
        w_result = 32'h0;
        case (w_alu_ctrl)
            C_AND: w_result = bus.rs_data & w_b;
            C_OR:  w_result = bus.rs_data | w_b;
            C_ADD: w_result = bus.rs_data + w_b;
            C_XOR: w_result = bus.rs_data ^ w_b;
            C_SUB: w_result = bus.rs_data - w_b;
            C_SLT: w_result = {31'h0, ($signed(bus.rs_data) < $signed(w_b))};
            C_SLL: w_result = w_b << bus.shamt;
            C_SRL: w_result = w_b >> bus.shamt;
            C_SRA: w_result = $unsigned($signed(w_b) >>> bus.shamt);
            C_LUI: w_result = {w_b[15:0], 16'h0};
            C_NOR: w_result = ~(bus.rs_data | w_b);
            default: w_result = 32'h0;
        endcase
    end

    // Byte address bits [1:0] are dropped; upper bits wrap modulo depth.
    assign w_idx = w_result[ADDR_BITS+1:2];

    // Data memory: reset wipes every word at once and masks a same-edge store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (bus.mem_write) begin
            r_mem[w_idx] <= bus.rt_data;
        end
    end

    assign bus.alu_ctrl      = w_alu_ctrl;
    assign bus.alu_result    = w_result;
    assign bus.zero          = (w_result == 32'h0);
    assign bus.mem_read_data = bus.mem_read ? r_mem[w_idx] : 32'h0;

endmodule

// File: tb/tb_alu_mem_unit.sv
// Directed + randomized bench for alu_mem_unit with a behavioural model
// (operation-by-name arithmetic plus a plain word array for memory).
module tb_alu_mem_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_mem_unit_if bus ();

    alu_mem_unit #(.MEM_WORDS(256), .ADDR_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mdl_mem [256];
    logic [31:0] exp_res;

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [5:0] fn,
                                                 input logic [4:0] sh, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: r = a ^ b;
            3'd7: r = b * 32'h10000;
            default: begin
                if      (fn == 6'h22 || fn == 6'h23) r = a - b;
                else if (fn == 6'h24) r = a & b;
                else if (fn == 6'h25) r = a | b;
                else if (fn == 6'h26) r = a ^ b;
                else if (fn == 6'h27) r = ~(a | b);
                else if (fn == 6'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else if (fn == 6'h00) r = b * (32'd1 << sh);
                else if (fn == 6'h02) r = b / (32'd1 << sh);
                else if (fn == 6'h03) r = (b / (32'd1 << sh)) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                else r = a + b;
            end
        endcase
        return r;
    endfunction

    function automatic logic [3:0] model_ctrl(input logic [2:0] op, input logic [5:0] fn);
        logic [3:0] c;
        case (op)
            3'd0: c = 4'b0010;
            3'd1: c = 4'b0110;
            3'd3: c = 4'b0000;
            3'd4: c = 4'b0001;
            3'd5: c = 4'b0111;
            3'd6: c = 4'b0011;
            3'd7: c = 4'b1011;
            default: begin
                case (fn)
                    6'h22, 6'h23: c = 4'b0110;
                    6'h24: c = 4'b0000;
                    6'h25: c = 4'b0001;
                    6'h26: c = 4'b0011;
                    6'h27: c = 4'b1100;
                    6'h2A: c = 4'b0111;
                    6'h00: c = 4'b1000;
                    6'h02: c = 4'b1001;
                    6'h03: c = 4'b1010;
                    default: c = 4'b0010;
                endcase
            end
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation and check every output against the model.
    task automatic apply(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic rd,
                         input logic wr);
        logic [31:0] b;
        bus.alu_op = op; bus.funct = fn; bus.shamt = sh;
        bus.rs_data = a; bus.rt_data = rt; bus.imm_ext = imm;
        bus.alu_src = src; bus.mem_read = rd; bus.mem_write = wr;
        b = src ? imm : rt;
        exp_res = model_result(op, fn, sh, a, b);
        #1;
        chk({tag, ".ctrl"}, {28'h0, bus.alu_ctrl}, {28'h0, model_ctrl(op, fn)});
        chk({tag, ".res"},  bus.alu_result, exp_res);
        chk({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, exp_res == 32'h0});
        chk({tag, ".rdat"}, bus.mem_read_data, rd ? mdl_mem[exp_res[9:2]] : 32'h0);
    endtask

    // One rising edge; the model commits a store unless reset masks it.
    task automatic edge_and_settle();
        @(posedge clk);
        if (!reset && bus.mem_write) mdl_mem[exp_res[9:2]] = bus.rt_data;
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fn_list [12];
        logic [2:0] op;
        logic [5:0] fn;
        logic [31:0] a, imm;
        checks = 0;
        failures = 0;
        fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
        model_clear();
        reset = 1'b1;
        bus.alu_op = 3'd0; bus.funct = 6'd0; bus.shamt = 5'd0;
        bus.rs_data = 32'h0; bus.rt_data = 32'h0; bus.imm_ext = 32'h0;
        bus.alu_src = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        repeat (2) @(negedge clk);
        apply("rst_read", 3'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'h10, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;

        // Store then load at byte address 4.
        apply("st4", 3'd0, 6'h0, 5'd0, 32'h0, 32'hDEADBEEF, 32'd4, 1'b1, 1'b0, 1'b1);
        chk("st4_res_const", bus.alu_result, 32'd4);
        edge_and_settle();
        apply("ld4", 3'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'd4, 1'b1, 1'b1, 1'b0);
        chk("ld4_const", bus.mem_read_data, 32'hDEADBEEF);
        apply("ld32", 3'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'd32, 1'b1, 1'b1, 1'b0);
        chk("ld32_const", bus.mem_read_data, 32'h0);

        // Same-word read during write: old value until the edge.
        apply("rw_old", 3'd0, 6'h0, 5'd0, 32'h0, 32'h12345678, 32'd4, 1'b1, 1'b1, 1'b1);
        chk("rw_old_const", bus.mem_read_data, 32'hDEADBEEF);
        edge_and_settle();
        apply("rw_new", 3'd0, 6'h0, 5'd0, 32'h0, 32'h12345678, 32'd4, 1'b1, 1'b1, 1'b0);
        chk("rw_new_const", bus.mem_read_data, 32'h12345678);

        // R-type sweep.
        apply("r_add", 3'd2, 6'h20, 5'd0, 32'hF, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_add_c", bus.alu_result, 32'hFF);
        apply("r_sub", 3'd2, 6'h22, 5'd0, 32'hF, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_sub_c", bus.alu_result, 32'hFFFFFF1F);
        apply("r_and", 3'd2, 6'h24, 5'd0, 32'hF, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_and_z", {31'h0, bus.zero}, 32'h1);
        apply("r_or", 3'd2, 6'h25, 5'd0, 32'hF, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        apply("r_nor", 3'd2, 6'h27, 5'd0, 32'hF, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_nor_c", bus.alu_result, 32'hFFFFFF00);
        apply("r_slt", 3'd2, 6'h2A, 5'd0, 32'hF, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        apply("r_bad", 3'd2, 6'h3F, 5'd0, 32'hF, 32'hF0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("r_bad_ctrl", {28'h0, bus.alu_ctrl}, 32'h2);

        // Branch compare.
        apply("beq_eq", 3'd1, 6'h0, 5'd0, 32'd7, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("beq_eq_z", {31'h0, bus.zero}, 32'h1);
        apply("beq_ne", 3'd1, 6'h0, 5'd0, 32'd7, 32'd8, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("beq_ne_r", bus.alu_result, 32'hFFFFFFFF);

        // Shifts and LUI.
        apply("sra", 3'd2, 6'h03, 5'd4, 32'h0, 32'h80000010, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sra_c", bus.alu_result, 32'hF8000001);
        apply("srl", 3'd2, 6'h02, 5'd4, 32'h0, 32'h80000010, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("srl_c", bus.alu_result, 32'h08000001);
        apply("lui", 3'd7, 6'h0, 5'd0, 32'h0, 32'h0, 32'h00001234, 1'b1, 1'b0, 1'b0);
        chk("lui_c", bus.alu_result, 32'h12340000);

        // Address aliasing: 0x403 lands on word 0.
        apply("alias_st", 3'd0, 6'h0, 5'd0, 32'h400, 32'hCAFEF00D, 32'd3, 1'b1, 1'b0, 1'b1);
        edge_and_settle();
        apply("alias_ld", 3'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("alias_c", bus.mem_read_data, 32'hCAFEF00D);

        // Mid-cycle async reset after storing at word 8.
        apply("w8_st", 3'd0, 6'h0, 5'd0, 32'h0, 32'h55AA55AA, 32'd32, 1'b1, 1'b0, 1'b1);
        edge_and_settle();
        apply("w8_ld", 3'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'd32, 1'b1, 1'b1, 1'b0);
        chk("w8_ld_c", bus.mem_read_data, 32'h55AA55AA);
        #1 reset = 1'b1;
        model_clear();
        #1;
        chk("async_rst_w8", bus.mem_read_data, 32'h0);
        apply("async_rst_w1", 3'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'd4, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Store with reset held across the edge is dropped.
        reset = 1'b1;
        apply("rst_st", 3'd0, 6'h0, 5'd0, 32'h0, 32'hAAAA5555, 32'd12, 1'b1, 1'b0, 1'b1);
        edge_and_settle();
        reset = 1'b0;
        apply("rst_st_ld", 3'd0, 6'h0, 5'd0, 32'h0, 32'h0, 32'd12, 1'b1, 1'b1, 1'b0);
        chk("rst_st_c", bus.mem_read_data, 32'h0);

        // Signed compare and wraparound add.
        apply("slti", 3'd5, 6'h0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("slti_c", bus.alu_result, 32'h1);
        apply("add_ovf", 3'd0, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
        chk("add_ovf_c", bus.alu_result, 32'h80000000);

        // Randomized mix against the model.
        for (int n = 0; n < 300; n++) begin
            op  = 3'($urandom_range(0, 7));
            fn  = ($urandom_range(0, 3) != 0) ? fn_list[$urandom_range(0, 11)] : 6'($urandom);
            a   = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                op  = 3'd0;
                a   = $urandom_range(0, 63);
                imm = $urandom_range(0, 63);
            end
            apply("rnd", op, fn, 5'($urandom), a, $urandom, imm, 1'($urandom),
                  1'($urandom), 1'($urandom));
            edge_and_settle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
